multi_phase_light_controller: RTL

MULTI_PHASE_LIGHT_CONTROLLER -- requirements
Module: multi_phase_light_controller

---
 rtl/multi_phase_light_controller.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/multi_phase_light_controller.sv
// multi_phase_light_controller
// Round-robin traffic light sequencer for NUM_DIRS approaches. Each phase is
// green, then yellow, then an all-red clearance gap. The green+yellow duration
// is chosen at the start of each phase from manual high-flow switches or from
// per-direction car counts. A stop-sign switch overrides everything with a
// flashing all-red pattern. Every output comes straight from a flop.
module multi_phase_light_controller #(
  parameter int NUM_DIRS       = 2,
  parameter int CNT_W          = 6,
  parameter int REGULAR_T      = 15,
  parameter int HIGH_T         = 18,
  parameter int LOW_T          = 10,
  parameter int YELLOW_T       = 3,
  parameter int ALL_RED_T      = 1,
  parameter int OVERFLOW_LIMIT = 5,
  parameter int COUNT_MAX      = 60
) (
  input  logic                      clk_1hz,
  input  logic                      reset_counts,
  input  logic                      stop_sign_sw,
  input  logic [NUM_DIRS-1:0]       high_sw,
  input  logic [NUM_DIRS-1:0]       car_pulse,
  output logic [NUM_DIRS-1:0]       green,
  output logic [NUM_DIRS-1:0]       yellow,
  output logic [NUM_DIRS-1:0]       red,
  output logic [1:0]                active_dir,
  output logic [CNT_W-1:0]          timer_val,
  output logic [NUM_DIRS-1:0]       high_led,
  output logic [NUM_DIRS*CNT_W-1:0] car_count
);

  // Clearance counter only needs to reach ALL_RED_T-1.
  localparam int         CLR_W    = (ALL_RED_T > 1) ? $clog2(ALL_RED_T) : 1;
  localparam logic [1:0] LAST_DIR = 2'(NUM_DIRS - 1);

  typedef enum logic [1:0] {
    ST_ALL_RED    = 2'd0,
    ST_GREEN      = 2'd1,
    ST_YELLOW     = 2'd2,
    ST_STOP_BLINK = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CLR_W-1:0]     clr_q, clr_d;
  logic [1:0]           dir_q, dir_d;
  logic [CNT_W-1:0]     timer_q, timer_d;
  logic [NUM_DIRS-1:0]  green_q, green_d;
  logic [NUM_DIRS-1:0]  yellow_q, yellow_d;
  logic [NUM_DIRS-1:0]  red_q, red_d;
  logic [NUM_DIRS-1:0]  led_q, led_d;
  logic                 blink_q, blink_d;
  logic [CNT_W-1:0]     count_q [NUM_DIRS];
  logic [CNT_W-1:0]     count_d [NUM_DIRS];

  // Duration-load arbitration results
  logic                 sw_hit, ovf_hit, hi_hit, lead_ok;
  logic [1:0]           sw_dir, ovf_dir, hi_dir, next_dir;
  logic [CNT_W-1:0]     load_dur;
  logic [NUM_DIRS-1:0]  load_led;
  logic                 any_max;

  // Pick the high-flow direction for the next load: lowest-index manual switch
  // wins, otherwise a direction whose count leads every other by the limit.
  always_comb begin
    sw_hit  = 1'b0;
    sw_dir  = 2'd0;
    ovf_hit = 1'b0;
    ovf_dir = 2'd0;
    lead_ok = 1'b0;
    // Descending scan so the lowest asserted index is the one left standing.
    for (int d = NUM_DIRS - 1; d >= 0; d--) begin
      if (high_sw[d]) begin
        sw_hit = 1'b1;
        sw_dir = 2'(d);
      end
    end
    // Comparisons done in int so count + limit cannot wrap at CNT_W bits.
    for (int d = NUM_DIRS - 1; d >= 0; d--) begin
      lead_ok = 1'b1;
      for (int o = 0; o < NUM_DIRS; o++) begin
        if (o != d && (int'(count_q[d]) < int'(count_q[o]) + OVERFLOW_LIMIT)) begin
          lead_ok = 1'b0;
        end
      end
      if (lead_ok) begin
        ovf_hit = 1'b1;
        ovf_dir = 2'(d);
      end
    end
    hi_hit   = sw_hit | ovf_hit;
    hi_dir   = sw_hit ? sw_dir : ovf_dir;
    next_dir = (dir_q == LAST_DIR) ? 2'd0 : dir_q + 2'd1;
    if (!hi_hit) begin
      load_dur = CNT_W'(REGULAR_T);
    end else if (hi_dir == next_dir) begin
      load_dur = CNT_W'(HIGH_T);
    end else begin
      load_dur = CNT_W'(LOW_T);
    end
    load_led = '0;
    for (int d = 0; d < NUM_DIRS; d++) begin
      if (hi_hit && hi_dir == 2'(d)) begin
        load_led[d] = 1'b1;
      end
    end
  end

  // Phase sequencing: next state, clearance count, direction, timer, indicator.
  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    dir_d   = dir_q;
    timer_d = timer_q;
    led_d   = led_q;
    blink_d = blink_q;
    if (stop_sign_sw) begin
      // Flashing mode: first cycle shows red on, then alternates.
      state_d = ST_STOP_BLINK;
      clr_d   = '0;
      timer_d = '0;
      led_d   = '0;
      blink_d = (state_q == ST_STOP_BLINK) ? ~blink_q : 1'b1;
    end else begin
      case (state_q)
        ST_ALL_RED: begin
          if (clr_q == CLR_W'(ALL_RED_T - 1)) begin
            state_d = ST_GREEN;
            clr_d   = '0;
            dir_d   = next_dir;
            timer_d = load_dur;
            led_d   = load_led;
          end else begin
            clr_d = clr_q + 1'b1;
          end
        end
        ST_GREEN: begin
          timer_d = timer_q - 1'b1;
          if (timer_d <= CNT_W'(YELLOW_T)) begin
            state_d = ST_YELLOW;
          end
        end
        ST_YELLOW: begin
          if (timer_q <= CNT_W'(1)) begin
            timer_d = '0;
            state_d = ST_ALL_RED;
            clr_d   = '0;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        ST_STOP_BLINK: begin
          // Leaving flashing mode restarts the rotation at direction 0.
          state_d = ST_ALL_RED;
          clr_d   = '0;
          dir_d   = LAST_DIR;
          timer_d = '0;
          blink_d = 1'b0;
        end
        default: begin
          state_d = ST_ALL_RED;
          clr_d   = '0;
        end
      endcase
    end
  end

  // Lamp drives are derived from the next state so they register alongside it.
  always_comb begin
    green_d  = '0;
    yellow_d = '0;
    red_d    = '1;
    case (state_d)
      ST_GREEN: begin
        for (int d = 0; d < NUM_DIRS; d++) begin
          if (dir_d == 2'(d)) begin
            green_d[d] = 1'b1;
            red_d[d]   = 1'b0;
          end
        end
      end
      ST_YELLOW: begin
        for (int d = 0; d < NUM_DIRS; d++) begin
          if (dir_d == 2'(d)) begin
            yellow_d[d] = 1'b1;
            red_d[d]    = 1'b0;
          end
        end
      end
      ST_STOP_BLINK: begin
        red_d = {NUM_DIRS{blink_d}};
      end
      default: begin
        red_d = '1;
      end
    endcase
  end

  // Car counters: count strobes, clear everything once any counter tops out,
  // and hold at zero while flashing.
  always_comb begin
    any_max = 1'b0;
    for (int d = 0; d < NUM_DIRS; d++) begin
      if (count_q[d] == CNT_W'(COUNT_MAX)) begin
        any_max = 1'b1;
      end
    end
    for (int d = 0; d < NUM_DIRS; d++) begin
      count_d[d] = count_q[d];
      if (stop_sign_sw || any_max) begin
        count_d[d] = '0;
      end else if (car_pulse[d]) begin
        count_d[d] = count_q[d] + 1'b1;
      end
    end
  end

  // State and output registers; reset_counts clears them without a clock.
  always_ff @(posedge clk_1hz or posedge reset_counts) begin
    if (reset_counts) begin
      state_q  <= ST_ALL_RED;
      clr_q    <= '0;
      dir_q    <= LAST_DIR;
      timer_q  <= '0;
      green_q  <= '0;
      yellow_q <= '0;
      red_q    <= '1;
      led_q    <= '0;
      blink_q  <= 1'b0;
      for (int d = 0; d < NUM_DIRS; d++) begin
        count_q[d] <= '0;
      end
    end else begin
      state_q  <= state_d;
      clr_q    <= clr_d;
      dir_q    <= dir_d;
      timer_q  <= timer_d;
      green_q  <= green_d;
      yellow_q <= yellow_d;
      red_q    <= red_d;
      led_q    <= led_d;
      blink_q  <= blink_d;
      for (int d = 0; d < NUM_DIRS; d++) begin
        count_q[d] <= count_d[d];
      end
    end
  end

  assign green      = green_q;
  assign yellow     = yellow_q;
  assign red        = red_q;
  assign active_dir = dir_q;
  assign timer_val  = timer_q;
  assign high_led   = led_q;

  // Pack the per-direction counters onto the flat output bus.
  for (genvar gi = 0; gi < NUM_DIRS; gi++) begin : g_count_pack
    assign car_count[gi*CNT_W +: CNT_W] = count_q[gi];
  end

endmodule
